// File: rtl/ready_board_if.sv
// Rename-to-scoreboard bundle: per-lane source/dest tags, writeback wake ports,
// flush, and the per-source readiness returned to dispatch.
interface ready_board_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned WAKE_N = 4,
    parameter int unsigned PREG_W = 6
);
    logic [LANES-1:0][PREG_W-1:0]  prj;
    logic [LANES-1:0][PREG_W-1:0]  prk;
    logic [LANES-1:0][PREG_W-1:0]  prd;
    logic [LANES-1:0]              rd_valid;
    logic [LANES-1:0]              rename_en;
    logic [WAKE_N-1:0]             wake_valid;
    logic [WAKE_N-1:0][PREG_W-1:0] wake_preg;
    logic                          predict_fail;
    logic [LANES-1:0]              prj_ready;
    logic [LANES-1:0]              prk_ready;

    modport master (
        output prj, prk, prd, rd_valid, rename_en, wake_valid, wake_preg, predict_fail,
        input  prj_ready, prk_ready
    );

    modport slave (
        input  prj, prk, prd, rd_valid, rename_en, wake_valid, wake_preg, predict_fail,
        output prj_ready, prk_ready
    );
endinterface

// File: rtl/ready_board.sv
// Physical-register busy scoreboard: allocations set busy, writebacks clear it,
// mispredict clears all; lookups are combinational with intra-group and wake bypass.
module ready_board #(
    parameter int unsigned PREG_NUM = 64,
    parameter int unsigned PREG_W   = 6,
    parameter int unsigned LANES    = 4,
    parameter int unsigned WAKE_N   = 4
) (
    input logic           clock,
    input logic           reset,
    ready_board_if.slave  io
);

    logic [PREG_NUM-1:0] busy_q;
    logic [PREG_NUM-1:0] busy_d;
    logic [LANES-1:0]    alloc_c;
    logic [LANES-1:0]    prj_ready_c;
    logic [LANES-1:0]    prk_ready_c;

    // p0 never counts as an allocation; it is architectural r0
    always_comb begin
        alloc_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            alloc_c[i] = io.rename_en[i] & io.rd_valid[i] & (io.prd[i] != '0);
        end
    end

    // Priority: flush > alloc > wake; a same-tag wake belongs to an older mapping
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < int'(WAKE_N); k++) begin
            if (io.wake_valid[k]) begin
                busy_d[io.wake_preg[k]] = 1'b0;
            end
        end
        for (int i = 0; i < int'(LANES); i++) begin
            if (alloc_c[i]) begin
                busy_d[io.prd[i]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        if (io.predict_fail) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Older lane's fresh destination hides both the wake bypass and stale state
    function automatic logic tag_ready(
        input logic [PREG_W-1:0]             tag,
        input int                            lane,
        input logic [LANES-1:0]              alloc,
        input logic [LANES-1:0][PREG_W-1:0]  prd,
        input logic [WAKE_N-1:0]             wake_valid,
        input logic [WAKE_N-1:0][PREG_W-1:0] wake_preg,
        input logic [PREG_NUM-1:0]           busy
    );
        logic hazard;
        logic bypass;
        hazard = 1'b0;
        bypass = 1'b0;
        for (int j = 0; j < int'(LANES); j++) begin
            if ((j < lane) && alloc[j] && (prd[j] == tag)) begin
                hazard = 1'b1;
            end
        end
        for (int k = 0; k < int'(WAKE_N); k++) begin
            if (wake_valid[k] && (wake_preg[k] == tag)) begin
                bypass = 1'b1;
            end
        end
        if (tag == '0) begin
            return 1'b1;
        end else if (hazard) begin
            return 1'b0;
        end else if (bypass) begin
            return 1'b1;
        end
        return ~busy[tag];
    endfunction

    always_comb begin
        prj_ready_c = '0;
        prk_ready_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            prj_ready_c[i] = tag_ready(io.prj[i], i, alloc_c, io.prd,
                                       io.wake_valid, io.wake_preg, busy_q);
            prk_ready_c[i] = tag_ready(io.prk[i], i, alloc_c, io.prd,
                                       io.wake_valid, io.wake_preg, busy_q);
        end
    end

    assign io.prj_ready = prj_ready_c;
    assign io.prk_ready = prk_ready_c;

endmodule

// File: tb/tb_ready_board.sv
// Directed scoreboard bench for ready_board: each step queues expected readiness
// and the queue is drained against the DUT before the next clock edge.
module tb_ready_board;
    localparam int unsigned PREG_W = 6;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ready_board_if #(.LANES(4), .WAKE_N(4), .PREG_W(PREG_W)) io ();

    ready_board #(
        .PREG_NUM(64),
        .PREG_W  (PREG_W),
        .LANES   (4),
        .WAKE_N  (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (io)
    );

    typedef struct {
        int   step;
        int   lane;
        bit   is_prk;
        logic exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;

    task automatic idle();
        io.prj          = '0;
        io.prk          = '0;
        io.prd          = '0;
        io.rd_valid     = '0;
        io.rename_en    = '0;
        io.wake_valid   = '0;
        io.wake_preg    = '0;
        io.predict_fail = 1'b0;
    endtask

    task automatic alloc(input int lane, input logic [PREG_W-1:0] tag);
        io.rename_en[lane] = 1'b1;
        io.rd_valid[lane]  = 1'b1;
        io.prd[lane]       = tag;
    endtask

    task automatic want(input int lane, input bit is_prk, input logic e);
        sb.push_back('{step, lane, is_prk, e});
    endtask

    // Let combinational lookups settle, then drain every queued expectation
    task automatic check();
        #2;
        while (sb.size() > 0) begin
            exp_t t;
            logic obs;
            t   = sb.pop_front();
            obs = t.is_prk ? io.prk_ready[t.lane] : io.prj_ready[t.lane];
            n_checks++;
            assert (obs === t.exp) else begin
                n_fail++;
                $error("FAIL step%0d %s_ready_%0d observed=%b expected=%b",
                       t.step, t.is_prk ? "prk" : "prj", t.lane, obs, t.exp);
            end
        end
        step++;
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        next();

        // Reset holds: everything ready
        io.prj[0] = 6'd5;
        io.prj[1] = 6'd17;
        io.prj[2] = 6'd40;
        io.prj[3] = 6'd63;
        for (int i = 0; i < 4; i++) begin
            want(i, 1'b0, 1'b1);
            want(i, 1'b1, 1'b1);
        end
        check();
        next();
        reset = 1'b0;

        // Alloc 12, intra-group hazard same cycle
        idle();
        alloc(0, 6'd12);
        io.prj[2] = 6'd12;
        want(2, 1'b0, 1'b0);
        check();
        next();
        for (int c = 1; c <= 2; c++) begin
            idle();
            io.prj[2] = 6'd12;
            want(2, 1'b0, 1'b0);
            check();
            next();
        end
        // Wake bypass same cycle, then from state
        idle();
        io.wake_valid[1] = 1'b1;
        io.wake_preg[1]  = 6'd12;
        io.prj[2]        = 6'd12;
        want(2, 1'b0, 1'b1);
        check();
        next();
        idle();
        io.prj[2] = 6'd12;
        want(2, 1'b0, 1'b1);
        check();
        next();

        // Intra-group: lane1 not renaming -> no hazard
        idle();
        io.rd_valid[1] = 1'b1;
        io.prd[1]      = 6'd20;
        io.prk[3]      = 6'd20;
        io.prk[0]      = 6'd20;
        want(3, 1'b1, 1'b1);
        want(0, 1'b1, 1'b1);
        check();
        next();
        // lane1 renaming -> younger lanes see hazard, older lane does not
        idle();
        alloc(1, 6'd20);
        io.prk[0] = 6'd20;
        io.prk[2] = 6'd20;
        io.prk[3] = 6'd20;
        want(3, 1'b1, 1'b0);
        want(2, 1'b1, 1'b0);
        want(0, 1'b1, 1'b1);
        check();
        next();
        idle();
        io.prk[0]        = 6'd20;
        io.prk[1]        = 6'd20;
        io.wake_valid[3] = 1'b1;
        io.wake_preg[3]  = 6'd20;
        want(1, 1'b1, 1'b1);
        io.wake_valid[2] = 1'b0;
        check();
        idle();
        io.prk[0] = 6'd20;
        want(0, 1'b1, 1'b0);
        check();
        io.wake_valid[3] = 1'b1;
        io.wake_preg[3]  = 6'd20;
        next();
        idle();
        io.prk[0] = 6'd20;
        want(0, 1'b1, 1'b1);
        check();
        next();

        // Alloc vs wake on same tag: alloc wins; hazard beats bypass
        idle();
        alloc(2, 6'd33);
        io.wake_valid[0] = 1'b1;
        io.wake_preg[0]  = 6'd33;
        io.prj[3]        = 6'd33;
        io.prj[1]        = 6'd33;
        want(3, 1'b0, 1'b0);
        want(1, 1'b0, 1'b1);
        check();
        next();
        idle();
        io.prj[0] = 6'd33;
        want(0, 1'b0, 1'b0);
        check();
        next();

        // Flush: busy 7,8,9; mispredict with concurrent alloc of 10
        idle();
        alloc(0, 6'd7);
        alloc(1, 6'd8);
        alloc(2, 6'd9);
        check();
        next();
        idle();
        io.predict_fail = 1'b1;
        alloc(0, 6'd10);
        io.prj[1] = 6'd7;
        io.prj[2] = 6'd8;
        io.prj[3] = 6'd9;
        want(1, 1'b0, 1'b0);
        want(2, 1'b0, 1'b0);
        want(3, 1'b0, 1'b0);
        check();
        next();
        idle();
        io.prj[0] = 6'd7;
        io.prj[1] = 6'd8;
        io.prj[2] = 6'd9;
        io.prj[3] = 6'd10;
        io.prk[0] = 6'd33;
        for (int i = 0; i < 4; i++) begin
            want(i, 1'b0, 1'b1);
        end
        want(0, 1'b1, 1'b1);
        check();
        next();

        // Tag 0 always ready and never becomes busy
        idle();
        alloc(0, 6'd0);
        io.prj[1] = 6'd0;
        want(1, 1'b0, 1'b1);
        check();
        next();
        idle();
        io.prj[0] = 6'd0;
        io.prk[3] = 6'd0;
        want(0, 1'b0, 1'b1);
        want(3, 1'b1, 1'b1);
        check();
        next();

        // Asynchronous reset mid-operation clears state without a clock edge
        idle();
        alloc(0, 6'd50);
        next();
        idle();
        io.prj[0] = 6'd50;
        want(0, 1'b0, 1'b0);
        check();
        reset = 1'b1;
        want(0, 1'b0, 1'b1);
        check();
        next();
        reset = 1'b0;
        idle();
        io.prj[0] = 6'd50;
        want(0, 1'b0, 1'b1);
        check();
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
